logic_gates: RTL and testbench
==============================

LOGIC_GATES -- requirements
Module: logic_gates

Interface
REQ-001 The block SHALL have parameter COV_AUTO_CLR, default 0, meaning: when 1, coverage clears automatically one cycle after all four input combinations are seen.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: clock; all registers update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port A, input, 1 bit: gate operand A.
REQ-006 Port B, input, 1 bit: gate operand B.
REQ-007 Port cov_clr, input, 1 bit: synchronous coverage clear, active-high.
REQ-008 Ports Buf, Not, And, Nand, Or, Nor, Xor, Xnor, output, 1 bit each: combinational gate results.
REQ-009 Port gates_q, output, 8 bits: registered gate vector.
REQ-010 Port cov, output, 4 bits: sticky input-combination coverage; bit index = {A,B}.
REQ-011 Port cov_done, output, 1 bit: registered flag, high when cov == 4'hF.

Function
REQ-012 Combinational outputs SHALL be Buf=A, Not=~A, And=A&B, Nand=~(A&B), Or=A|B, Nor=~(A|B), Xor=A^B, Xnor=~(A^B).
REQ-013 Combinational outputs SHALL have zero-cycle latency, SHALL NOT depend on clk or rst_n, and SHALL be valid with clk idle.
REQ-014 gates_q SHALL load {Xnor,Xor,Nor,Or,Nand,And,Not,Buf} (bit7..bit0) every rising clk edge, giving 1-cycle latency.
REQ-015 Each rising edge SHALL set cov[{A,B}] to 1; set bits stay set until cleared.
REQ-016 When cov_clr=1 at an edge, cov SHALL become 0 and the current combination SHALL NOT be recorded that cycle (clear wins).
REQ-017 cov_done SHALL register (next-state cov == 4'hF) and therefore rise on the same edge that sets the last missing bit.
REQ-018 With COV_AUTO_CLR=1 and cov_done=1 at an edge, cov and cov_done SHALL clear at that edge.
REQ-019 With COV_AUTO_CLR=0, cov and cov_done SHALL hold until cov_clr or reset.
REQ-020 X/Z on A or B SHALL NOT be recorded into cov.

Reset
REQ-021 While rst_n=0: gates_q=8'h00, cov=4'h0, cov_done=0, applied immediately without waiting for a clock edge.
REQ-022 Reset asserted mid-operation SHALL discard coverage immediately; combinational outputs SHALL keep following A and B.
REQ-023 After rst_n deasserts, the first rising edge SHALL resume normal register updates.

Verification
REQ-024 Bench SHALL drive clk stopped, rst_n=0, and AB = 00, 01, 10, 11 (100 ns each). Required outputs {Xnor..Buf}: 0xAA, 0x5A, 0x59, 0x95 respectively, matching the truth table within each step.
REQ-025 Bench SHALL release reset, hold AB=01, and apply one edge. Required: gates_q=0x5A and cov=4'b0010 after the edge; gates_q is still 0x00 before the edge.
REQ-026 Bench SHALL apply AB sequence 00, 01, 10, 11, one per edge, with COV_AUTO_CLR=0. Required: cov=4'hF and cov_done=1 after the 4th edge, and both hold over 3 further edges.
REQ-027 Bench SHALL set cov_clr=1 with AB=11 for one edge. Required: cov=0 and cov_done=0 (bit3 not set).
REQ-028 Bench SHALL repeat the REQ-026 sequence with COV_AUTO_CLR=1. Required: cov_done=1 for exactly one cycle, then cov=0 and cov_done=0.
REQ-029 Bench SHALL pulse rst_n low between clock edges after partial coverage. Required: cov, cov_done and gates_q are zero immediately, and combinational outputs are unchanged.

Source files
------------

// File: rtl/logic_gates.sv
// Two-input gate bank with a registered copy of the gate vector and sticky
// coverage of the four {A,B} input combinations.
module logic_gates #(
    parameter bit COV_AUTO_CLR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       cov_clr,
    output logic       Buf,
    output logic       Not,
    output logic       And,
    output logic       Nand,
    output logic       Or,
    output logic       Nor,
    output logic       Xor,
    output logic       Xnor,
    output logic [7:0] gates_q,
    output logic [3:0] cov,
    output logic       cov_done
);

    logic [7:0] gates_p0;
    logic [3:0] cov_p0;
    logic       done_p0;
    logic       ab_known;
    logic       cov_wipe;

    assign Buf  = A;
    assign Not  = ~A;
    assign And  = A & B;
    assign Nand = ~(A & B);
    assign Or   = A | B;
    assign Nor  = ~(A | B);
    assign Xor  = A ^ B;
    assign Xnor = ~(A ^ B);

    assign gates_p0 = {Xnor, Xor, Nor, Or, Nand, And, Not, Buf};

    // An unknown operand must never mark a combination as seen.
    assign ab_known = ((A ^ B) === 1'b0) || ((A ^ B) === 1'b1);
    assign cov_wipe = cov_clr || (COV_AUTO_CLR && cov_done);

    always_comb begin
        cov_p0 = cov;
        if (cov_wipe) begin
            cov_p0 = 4'h0;
        end else if (ab_known) begin
            cov_p0[{A, B}] = 1'b1;
        end
    end

    assign done_p0 = (cov_p0 == 4'hF);

    // Stage p0 -> registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gates_q  <= 8'h00;
            cov      <= 4'h0;
            cov_done <= 1'b0;
        end else begin
            gates_q  <= gates_p0;
            cov      <= cov_p0;
            cov_done <= done_p0;
        end
    end

endmodule

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates: one instance without and one with coverage
// auto-clear, checked through a scoreboard queue drained by a monitor.
`timescale 1ns/1ps
module tb_logic_gates;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic A = 1'b0;
    logic B = 1'b0;
    logic cov_clr = 1'b0;

    logic       buf0, not0, and0, nand0, or0, nor0, xor0, xnor0;
    logic       buf1, not1, and1, nand1, or1, nor1, xor1, xnor1;
    logic [7:0] gq0, gq1;
    logic [3:0] cov0, cov1;
    logic       done0, done1;

    logic_gates #(.COV_AUTO_CLR(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cov_clr(cov_clr),
        .Buf(buf0), .Not(not0), .And(and0), .Nand(nand0), .Or(or0), .Nor(nor0),
        .Xor(xor0), .Xnor(xnor0), .gates_q(gq0), .cov(cov0), .cov_done(done0)
    );

    logic_gates #(.COV_AUTO_CLR(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .cov_clr(cov_clr),
        .Buf(buf1), .Not(not1), .And(and1), .Nand(nand1), .Or(or1), .Nor(nor1),
        .Xor(xor1), .Xnor(xnor1), .gates_q(gq1), .cov(cov1), .cov_done(done1)
    );

    typedef struct {
        string      tag;
        bit         inst;
        logic [7:0] comb;
        logic [7:0] q;
        logic [3:0] cv;
        logic       dn;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Hand-computed {Xnor..Buf} for AB = 00, 01, 10, 11
    logic [7:0] comb_tab [4] = '{8'hAA, 8'h5A, 8'h59, 8'h95};

    task automatic cmp(input string tag, input string fld, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%02h required=0x%02h", tag, fld, act, req);
        end
    endtask

    // Monitor: pops each expectation and compares it against the live outputs
    initial begin
        exp_t e;
        logic [7:0] c;
        forever begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (!e.inst) begin
                    c = {xnor0, xor0, nor0, or0, nand0, and0, not0, buf0};
                    cmp(e.tag, "comb", c, e.comb);
                    cmp(e.tag, "gates_q", gq0, e.q);
                    cmp(e.tag, "cov", {4'h0, cov0}, {4'h0, e.cv});
                    cmp(e.tag, "cov_done", {7'h0, done0}, {7'h0, e.dn});
                end else begin
                    c = {xnor1, xor1, nor1, or1, nand1, and1, not1, buf1};
                    cmp(e.tag, "comb", c, e.comb);
                    cmp(e.tag, "gates_q", gq1, e.q);
                    cmp(e.tag, "cov", {4'h0, cov1}, {4'h0, e.cv});
                    cmp(e.tag, "cov_done", {7'h0, done1}, {7'h0, e.dn});
                end
            end else begin
                #1;
            end
        end
    end

    task automatic expect_st(input string tag, input bit inst, input logic [7:0] comb,
                             input logic [7:0] q, input logic [3:0] cv, input logic dn);
        exp_t e;
        e.tag = tag; e.inst = inst; e.comb = comb; e.q = q; e.cv = cv; e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 5 && sb.size() != 0; i++) #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s.drain actual=%0d pending required=0 pending", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic both(input string tag, input logic [7:0] comb, input logic [7:0] q,
                        input logic [3:0] cv0, input logic d0, input logic [3:0] cv1, input logic d1);
        expect_st(tag, 1'b0, comb, q, cv0, d0);
        expect_st(tag, 1'b1, comb, q, cv1, d1);
        drain(tag);
    endtask

    task automatic set_ab(input logic [1:0] ab);
        A = ab[1];
        B = ab[0];
    endtask

    // Drive AB with clk low, then raise clk and leave 1 ns before sampling
    task automatic edge_ab(input logic [1:0] ab);
        clk = 1'b0;
        set_ab(ab);
        #4;
        clk = 1'b1;
        #1;
    endtask

    initial begin
        // Clock stopped, reset held: combinational truth table
        for (int i = 0; i < 4; i++) begin
            set_ab(2'(i));
            #100;
            both($sformatf("rst_ab%0d", i), comb_tab[i], 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
        end

        set_ab(2'b01);
        #10;
        rst_n = 1'b1;
        #5;
        both("pre_edge", comb_tab[1], 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
        edge_ab(2'b01);
        both("first_edge", comb_tab[1], 8'h5A, 4'b0010, 1'b0, 4'b0010, 1'b0);

        edge_ab(2'b00);
        both("seq_e1", comb_tab[0], 8'hAA, 4'b0011, 1'b0, 4'b0011, 1'b0);
        edge_ab(2'b01);
        both("seq_e2", comb_tab[1], 8'h5A, 4'b0011, 1'b0, 4'b0011, 1'b0);
        edge_ab(2'b10);
        both("seq_e3", comb_tab[2], 8'h59, 4'b0111, 1'b0, 4'b0111, 1'b0);
        edge_ab(2'b11);
        both("seq_e4", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'hF, 1'b1);
        edge_ab(2'b11);
        both("hold_e5", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'h0, 1'b0);
        edge_ab(2'b11);
        both("hold_e6", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'b1000, 1'b0);
        edge_ab(2'b11);
        both("hold_e7", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'b1000, 1'b0);

        // Clear beats recording of AB=11
        cov_clr = 1'b1;
        edge_ab(2'b11);
        both("clr_wins", comb_tab[3], 8'h95, 4'h0, 1'b0, 4'h0, 1'b0);
        clk = 1'b0;
        cov_clr = 1'b0;

        edge_ab(2'b00);
        both("auto_e1", comb_tab[0], 8'hAA, 4'b0001, 1'b0, 4'b0001, 1'b0);
        edge_ab(2'b01);
        both("auto_e2", comb_tab[1], 8'h5A, 4'b0011, 1'b0, 4'b0011, 1'b0);
        edge_ab(2'b10);
        both("auto_e3", comb_tab[2], 8'h59, 4'b0111, 1'b0, 4'b0111, 1'b0);
        edge_ab(2'b11);
        both("auto_e4", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'hF, 1'b1);
        edge_ab(2'b11);
        both("auto_e5", comb_tab[3], 8'h95, 4'hF, 1'b1, 4'h0, 1'b0);

        cov_clr = 1'b1;
        edge_ab(2'b00);
        both("clr2", comb_tab[0], 8'hAA, 4'h0, 1'b0, 4'h0, 1'b0);
        clk = 1'b0;
        cov_clr = 1'b0;
        edge_ab(2'b10);
        both("part_e1", comb_tab[2], 8'h59, 4'b0100, 1'b0, 4'b0100, 1'b0);
        edge_ab(2'b01);
        both("part_e2", comb_tab[1], 8'h5A, 4'b0110, 1'b0, 4'b0110, 1'b0);

        // Reset pulse between edges: registers zero at once, gates keep following AB
        clk = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        both("mid_rst", comb_tab[1], 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
        set_ab(2'b11);
        #1;
        both("rst_comb", comb_tab[3], 8'h00, 4'h0, 1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        #2;
        edge_ab(2'b01);
        both("post_rst", comb_tab[1], 8'h5A, 4'b0010, 1'b0, 4'b0010, 1'b0);

        clk = 1'b0;
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
